uart_controller: RTL and testbench

Full-duplex 8N1 UART controller bridging on-chip logic to one physical TX pin and one physical RX pin. It provides a level-requested, done-acknowledged byte transmitter and an oversampling byte receiver with a one-cycle data-valid strobe. It is the serial link endpoint of the FPGA top level.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx.sv | 131 +++++++++++++
 rtl/uart_controller.sv | 141 ++++++++++++++
 tb/tb_uart_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the 8N1 UART controller.
//   - tx_state_t / rx_state_t : FSM state encodings for the transmitter and receiver
//   - DATA_BITS, START_LVL, STOP_LVL, IDLE_LVL : frame format constants
//   - baud_div() : bit period in clock cycles (integer truncation)
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_DONE
   } tx_state_t;

   // RX_FERR holds the receiver after a bad stop bit until the line is high again.
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_FERR
   } rx_state_t;

   localparam int   DATA_BITS = 8;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 byte receiver.
//   iClk, iRst       : clock, synchronous active-high reset
//   iEn, iRxEn       : both must be high for the receiver to run; either low aborts a frame
//   iRxPin           : asynchronous serial input (2-flop synchronized internally)
//   oRxData          : last good byte, held until the next good frame
//   oRxDataValid     : one-cycle pulse when oRxData updates
// Start is detected on a high->low transition of the synchronized line, resampled
// at half a bit to reject glitches, then each bit is sampled at mid-bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iEn,
   input  logic       iRxEn,
   input  logic       iRxPin,
   output logic [7:0] oRxData,
   output logic       oRxDataValid
);

   localparam int DIV   = baud_div(CLK_FREQ, BAUD);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s1;
   logic                 rx_s2;
   logic                 rx_prev;
   logic                 fall;
   logic                 run;
   rx_state_t            rx_state;
   logic [CNT_W-1:0]     rx_cnt;
   logic [IDX_W-1:0]     rx_idx;
   logic [DATA_BITS-1:0] rx_shift;

   // Synchronizer stages reset to the idle level so reset never looks like a start edge.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         rx_s1   <= IDLE_LVL;
         rx_s2   <= IDLE_LVL;
         rx_prev <= IDLE_LVL;
      end else begin
         rx_s1   <= iRxPin;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign fall = (rx_prev == IDLE_LVL) && (rx_s2 == START_LVL);
   assign run  = iEn && iRxEn;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_idx       <= '0;
         oRxData      <= '0;
         oRxDataValid <= 1'b0;
      end else if (!run) begin
         rx_state     <= RX_IDLE;
         oRxDataValid <= 1'b0;
      end else begin
         oRxDataValid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (fall) begin
                  rx_cnt   <= CNT_HALF;
                  rx_state <= RX_START;
               end
            end

            RX_START: begin
               if (rx_cnt == '0) begin
                  if (rx_s2 != START_LVL) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_cnt   <= CNT_FULL;
                     rx_idx   <= '0;
                     rx_state <= RX_DATA;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end

            RX_DATA: begin
               if (rx_cnt == '0) begin
                  rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                  rx_cnt   <= CNT_FULL;
                  if (rx_idx == IDX_LAST) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_idx <= rx_idx + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end

            RX_STOP: begin
               if (rx_cnt == '0) begin
                  if (rx_s2 == STOP_LVL) begin
                     oRxData      <= rx_shift;
                     oRxDataValid <= 1'b1;
                     rx_state     <= RX_IDLE;
                  end else begin
                     rx_state <= RX_FERR;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end

            RX_FERR: begin
               if (rx_s2 == IDLE_LVL) begin
                  rx_state <= RX_IDLE;
               end
            end

            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_controller.sv
// uart_controller: full-duplex 8N1 UART endpoint (transmitter + optional receiver).
//   iClk, iRst     : clock, synchronous active-high reset
//   iEn            : global enable; low holds/aborts both directions to idle
//   iTxEn, iTxData : level transmit request and byte (byte captured on the accept edge)
//   oTxDone        : one-cycle pulse after the stop bit
//   oTxPin         : serial output, idle high
//   iRxEn, iRxPin  : receiver enable and asynchronous serial input
//   oRxData, oRxDataValid : last good byte and its one-cycle update strobe
// Build option: define UART_RX_EN to include the receiver (uart_rx). Without it the
// receive outputs are tied to zero and iRxEn/iRxPin are unused.
module uart_controller
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iEn,
   input  logic       iTxEn,
   input  logic [7:0] iTxData,
   output logic       oTxDone,
   output logic       oTxPin,
   input  logic       iRxEn,
   output logic [7:0] oRxData,
   output logic       oRxDataValid,
   input  logic       iRxPin
);

   localparam int DIV   = baud_div(CLK_FREQ, BAUD);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   tx_state_t            tx_state;
   logic [CNT_W-1:0]     tx_cnt;
   logic [IDX_W-1:0]     tx_idx;
   logic [DATA_BITS-1:0] tx_shift;

   // The pin is registered and always holds the level of the current bit; the
   // shift register is pre-shifted so bit 0 is always the next bit to drive.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         oTxPin   <= IDLE_LVL;
         oTxDone  <= 1'b0;
      end else if (!iEn && (tx_state != TX_IDLE)) begin
         tx_state <= TX_IDLE;
         oTxPin   <= IDLE_LVL;
         oTxDone  <= 1'b0;
      end else begin
         oTxDone <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               oTxPin <= IDLE_LVL;
               if (iEn && iTxEn) begin
                  tx_shift <= iTxData;
                  tx_cnt   <= CNT_FULL;
                  oTxPin   <= START_LVL;
                  tx_state <= TX_START;
               end
            end

            TX_START: begin
               if (tx_cnt == '0) begin
                  oTxPin   <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                  tx_idx   <= '0;
                  tx_cnt   <= CNT_FULL;
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end

            TX_DATA: begin
               if (tx_cnt == '0) begin
                  tx_cnt <= CNT_FULL;
                  if (tx_idx == IDX_LAST) begin
                     oTxPin   <= STOP_LVL;
                     tx_state <= TX_STOP;
                  end else begin
                     oTxPin   <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                     tx_idx   <= tx_idx + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end

            TX_STOP: begin
               if (tx_cnt == '0) begin
                  oTxPin   <= IDLE_LVL;
                  oTxDone  <= 1'b1;
                  tx_state <= TX_DONE;
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end

            // One-cycle acknowledge; a request still pending is taken from IDLE next cycle.
            TX_DONE: begin
               oTxPin   <= IDLE_LVL;
               tx_state <= TX_IDLE;
            end

            default: begin
               oTxPin   <= IDLE_LVL;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

`ifdef UART_RX_EN
   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_rx (
      .iClk         (iClk),
      .iRst         (iRst),
      .iEn          (iEn),
      .iRxEn        (iRxEn),
      .iRxPin       (iRxPin),
      .oRxData      (oRxData),
      .oRxDataValid (oRxDataValid)
   );
`else
   logic unused_rx;

   assign unused_rx    = iRxPin ^ iRxEn;
   assign oRxData      = '0;
   assign oRxDataValid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: directed bench for uart_controller with a short bit period
// (DIV = 16). Receiver scenarios are compiled when UART_RX_EN is defined; otherwise
// the tied-off receive outputs are checked.
module tb_uart_controller;

   localparam int CLK_FREQ = 1600;
   localparam int BAUD     = 100;
   localparam int DIV      = CLK_FREQ / BAUD;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       en       = 1'b0;
   logic       tx_en    = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_done;
   logic       tx_pin;
   logic       rx_en    = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_pin;
   logic       loop     = 1'b0;
   logic       rx_drv   = 1'b1;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int vld_cnt  = 0;
   int cyc      = 0;
   int vld_cyc  = 0;
   int d0;
   int v0;
   int e0c;

   assign rx_pin = loop ? tx_pin : rx_drv;

   always #5 clk = ~clk;

   uart_controller #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .iClk         (clk),
      .iRst         (rst),
      .iEn          (en),
      .iTxEn        (tx_en),
      .iTxData      (tx_data),
      .oTxDone      (tx_done),
      .oTxPin       (tx_pin),
      .iRxEn        (rx_en),
      .oRxData      (rx_data),
      .oRxDataValid (rx_valid),
      .iRxPin       (rx_pin)
   );

   // Pulse counters; cyc is the number of edges seen before the current one.
   always @(posedge clk) begin
      if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
      if (rx_valid === 1'b1) begin
         vld_cnt <= vld_cnt + 1;
         vld_cyc <= cyc;
      end
      cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Called #1 after the accept edge; returns #1 after the edge that ends the stop bit.
   task automatic tx_frame_chk(input logic [7:0] d, input string tag);
      logic lvl;
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      lvl = 1'b0;
         else if (k == 9) lvl = 1'b1;
         else             lvl = d[k-1];
         chk($sformatf("%s bit%0d first", tag, k), 32'(tx_pin), 32'(lvl));
         ticks(DIV - 1);
         chk($sformatf("%s bit%0d last", tag, k), 32'(tx_pin), 32'(lvl));
         if (k == 9) chk($sformatf("%s done early", tag), 32'(tx_done), 32'd0);
         tick();
      end
      chk($sformatf("%s done", tag), 32'(tx_done), 32'd1);
      chk($sformatf("%s pin after stop", tag), 32'(tx_pin), 32'd1);
   endtask

   task automatic rx_send(input logic [7:0] d, input logic stop);
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      rx_drv = 1'b0;
         else if (k == 9) rx_drv = stop;
         else             rx_drv = d[k-1];
         ticks(DIV);
      end
      rx_drv = 1'b1;
   endtask

   initial begin
      ticks(3);
      chk("reset pin", 32'(tx_pin), 32'd1);
      chk("reset done", 32'(tx_done), 32'd0);
      chk("reset rx_data", 32'(rx_data), 32'h00);
      chk("reset rx_valid", 32'(rx_valid), 32'd0);
      rst = 1'b0;
      ticks(2);

      // Single frame 0x55; data changed after acceptance must not leak in.
      d0 = done_cnt;
      en = 1'b1; tx_en = 1'b1; tx_data = 8'h55;
      tick();
      tx_data = 8'hFF;
      tx_frame_chk(8'h55, "tx55");
      tx_en = 1'b0;
      tick();
      chk("tx55 done pulse width", 32'(tx_done), 32'd0);
      chk("tx55 pin idle", 32'(tx_pin), 32'd1);
      ticks(DIV);
      chk("tx55 pin still idle", 32'(tx_pin), 32'd1);
      chk("tx55 done count", 32'(done_cnt - d0), 32'd1);

      // Back-to-back frames with the request held high.
      d0 = done_cnt;
      tx_data = 8'hA5; tx_en = 1'b1;
      tick();
      tx_data = 8'h3C;
      tx_frame_chk(8'hA5, "b2b A5");
      tick();
      chk("b2b gap pin", 32'(tx_pin), 32'd1);
      chk("b2b gap done", 32'(tx_done), 32'd0);
      tick();
      tx_frame_chk(8'h3C, "b2b 3C");
      tx_en = 1'b0;
      ticks(4);
      chk("b2b done count", 32'(done_cnt - d0), 32'd2);
      chk("b2b pin idle", 32'(tx_pin), 32'd1);

      // Enable dropped mid-frame.
      d0 = done_cnt;
      tx_data = 8'h00; tx_en = 1'b1;
      tick();
      ticks(5 * DIV);
      chk("abort pin before", 32'(tx_pin), 32'd0);
      en = 1'b0;
      tick();
      chk("abort pin", 32'(tx_pin), 32'd1);
      ticks(12 * DIV);
      chk("abort pin held", 32'(tx_pin), 32'd1);
      chk("abort no done", 32'(done_cnt - d0), 32'd0);
      tx_data = 8'h81;
      en = 1'b1;
      tick();
      tx_frame_chk(8'h81, "post abort");
      tx_en = 1'b0;
      tick();
      chk("post abort done count", 32'(done_cnt - d0), 32'd1);

      // Reset mid-frame.
      d0 = done_cnt;
      tx_data = 8'h00; tx_en = 1'b1;
      tick();
      ticks(4 * DIV + 3);
      rst = 1'b1; tx_en = 1'b0;
      tick();
      chk("rst pin", 32'(tx_pin), 32'd1);
      chk("rst done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      ticks(12 * DIV);
      chk("rst no done", 32'(done_cnt - d0), 32'd0);
      tx_data = 8'hE7; tx_en = 1'b1;
      tick();
      tx_frame_chk(8'hE7, "post rst");
      tx_en = 1'b0;
      tick();
      chk("post rst done count", 32'(done_cnt - d0), 32'd1);

`ifdef UART_RX_EN
      // Loopback of 0xC3 through the receiver.
      rx_en = 1'b1; loop = 1'b1;
      v0 = vld_cnt;
      tx_data = 8'hC3; tx_en = 1'b1;
      tick();
      e0c = cyc;
      tx_frame_chk(8'hC3, "loop");
      tx_en = 1'b0;
      ticks(DIV);
      chk("loop rx_data", 32'(rx_data), 32'h0000_00C3);
      chk("loop valid count", 32'(vld_cnt - v0), 32'd1);
      chk("loop valid latency", 32'(vld_cyc - e0c), 32'(DIV * 19 / 2 + 3));
      loop = 1'b0;
      ticks(4);

      // Framing error, then a good frame.
      v0 = vld_cnt;
      rx_send(8'h5A, 1'b0);
      ticks(2 * DIV);
      chk("ferr no valid", 32'(vld_cnt - v0), 32'd0);
      chk("ferr data held", 32'(rx_data), 32'h0000_00C3);
      rx_send(8'h12, 1'b1);
      ticks(2 * DIV);
      chk("after ferr data", 32'(rx_data), 32'h0000_0012);
      chk("after ferr valid count", 32'(vld_cnt - v0), 32'd1);

      // Short low glitch, then a good frame.
      v0 = vld_cnt;
      rx_drv = 1'b0;
      ticks(DIV / 2 - 2);
      rx_drv = 1'b1;
      ticks(2 * DIV);
      chk("glitch no valid", 32'(vld_cnt - v0), 32'd0);
      chk("glitch data held", 32'(rx_data), 32'h0000_0012);
      rx_send(8'h7E, 1'b1);
      ticks(2 * DIV);
      chk("after glitch data", 32'(rx_data), 32'h0000_007E);
      chk("after glitch valid count", 32'(vld_cnt - v0), 32'd1);

      // Receiver disabled ignores a frame.
      v0 = vld_cnt;
      rx_en = 1'b0;
      rx_send(8'h55, 1'b1);
      ticks(2 * DIV);
      chk("rx disabled no valid", 32'(vld_cnt - v0), 32'd0);
      chk("rx disabled data held", 32'(rx_data), 32'h0000_007E);
`else
      // Receiver not built: outputs stay tied off whatever arrives on the pin.
      v0 = vld_cnt;
      rx_en = 1'b1;
      rx_send(8'hA5, 1'b1);
      ticks(2 * DIV);
      chk("norx rx_data", 32'(rx_data), 32'h00);
      chk("norx valid count", 32'(vld_cnt - v0), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
